count_checker: RTL and testbench



---
 rtl/count_checker_pkg.sv | 14 +
 rtl/sat_counter.sv | 19 +
 rtl/count_checker.sv | 99 +++++++++
 tb/tb_count_checker.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/count_checker_pkg.sv
// rtl/count_checker_pkg.sv - shared state encoding and default sizes for count_checker
package count_checker_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int DEF_WIDTH    = 32;
  localparam int DEF_LOCK_CNT = 4;
  localparam int DEF_ERR_W    = 16;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up-counter that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] value
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      value <= '0;
    end else if (inc && (value != {W{1'b1}})) begin
      value <= value + 1'b1;
    end
  end

endmodule

// File: rtl/count_checker.sv
// rtl/count_checker.sv - locks onto a +1 count sequence and tallies discontinuities
// COUNT_CHECKER_STICKY_EN adds err_clear / err_sticky.
module count_checker
  import count_checker_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int LOCK_CNT = DEF_LOCK_CNT,
  parameter int ERR_W    = DEF_ERR_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             check_en,
  input  logic [WIDTH-1:0] count_in,
`ifdef COUNT_CHECKER_STICKY_EN
  input  logic             err_clear,
  output logic             err_sticky,
`endif
  output logic             locked,
  output logic             error,
  output logic [ERR_W-1:0] error_count,
  output logic [WIDTH-1:0] expected
);

  localparam int GW = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
  localparam logic [GW-1:0] LAST_GOOD = GW'(LOCK_CNT - 1);

  state_t        state;
  logic [GW-1:0] good_cnt;
  logic          match;
  logic          err_hit;

  assign match   = (count_in == expected);
  assign err_hit = check_en && (state == LOCKED) && !match;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      good_cnt <= '0;
      expected <= '0;
      locked   <= 1'b0;
      error    <= 1'b0;
    end else begin
      error <= err_hit;
      if (!check_en) begin
        state  <= IDLE;
        locked <= 1'b0;
      end else begin
        expected <= count_in + 1'b1;
        case (state)
          IDLE: begin
            good_cnt <= '0;
            state    <= SYNC;
          end
          SYNC: begin
            if (!match) begin
              good_cnt <= '0;
            end else if (good_cnt == LAST_GOOD) begin
              good_cnt <= '0;
              state    <= LOCKED;
              locked   <= 1'b1;
            end else begin
              good_cnt <= good_cnt + 1'b1;
            end
          end
          LOCKED: begin
            if (!match) begin
              good_cnt <= '0;
              state    <= SYNC;
              locked   <= 1'b0;
            end
          end
          default: begin
            state  <= IDLE;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (err_hit),
    .value (error_count)
  );

`ifdef COUNT_CHECKER_STICKY_EN
  // A new error wins over a simultaneous clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_sticky <= 1'b0;
    end else begin
      err_sticky <= err_hit | (err_sticky & ~err_clear);
    end
  end
`endif

endmodule

// File: tb/tb_count_checker.sv
// tb/tb_count_checker.sv - directed bench for count_checker with a run-length reference model
module tb_count_checker;

  localparam int LOCK = 4;

  logic        clock;
  logic        reset;
  logic        check_en;
  logic [31:0] count_in;
  logic        err_clear;

  logic        locked, error;
  logic [15:0] error_count;
  logic [31:0] expected;
  logic        locked_s, error_s;
  logic [1:0]  error_count_s;
  logic [31:0] expected_s;
`ifdef COUNT_CHECKER_STICKY_EN
  logic        err_sticky, err_sticky_s;
`endif

  int checks = 0;
  int errors = 0;

  count_checker dut (
    .clock       (clock),
    .reset       (reset),
    .check_en    (check_en),
    .count_in    (count_in),
`ifdef COUNT_CHECKER_STICKY_EN
    .err_clear   (err_clear),
    .err_sticky  (err_sticky),
`endif
    .locked      (locked),
    .error       (error),
    .error_count (error_count),
    .expected    (expected)
  );

  count_checker #(.ERR_W(2)) dut_sat (
    .clock       (clock),
    .reset       (reset),
    .check_en    (check_en),
    .count_in    (count_in),
`ifdef COUNT_CHECKER_STICKY_EN
    .err_clear   (err_clear),
    .err_sticky  (err_sticky_s),
`endif
    .locked      (locked_s),
    .error       (error_s),
    .error_count (error_count_s),
    .expected    (expected_s)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: length of the current run of +1 steps since the last break.
  logic        m_active, m_locked, m_error, m_sticky, m_hit;
  int          m_run, m_errs;
  logic [31:0] m_last, m_exp;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_active = 0; m_locked = 0; m_error = 0; m_sticky = 0;
      m_run = 0; m_errs = 0; m_last = 0; m_exp = 0;
    end else begin
      m_hit = 0;
      if (check_en) begin
        if (!m_active) begin
          m_active = 1;
          m_run    = 0;
        end else if (count_in == m_last + 32'd1) begin
          m_run++;
        end else begin
          m_hit = (m_run >= LOCK);
          m_run = 0;
        end
        m_last = count_in;
        m_exp  = count_in + 32'd1;
      end else begin
        m_active = 0;
        m_run    = 0;
      end
      m_error  = m_hit;
      if (m_hit) m_errs++;
      m_locked = m_active && (m_run >= LOCK);
      m_sticky = m_hit | (m_sticky & ~err_clear);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    chk("m.locked", 64'(locked), 64'(m_locked));
    chk("m.error", 64'(error), 64'(m_error));
    chk("m.error_count", 64'(error_count), 64'((m_errs > 65535) ? 65535 : m_errs));
    chk("m.expected", 64'(expected), 64'(m_exp));
    chk("m.sat.locked", 64'(locked_s), 64'(m_locked));
    chk("m.sat.error", 64'(error_s), 64'(m_error));
    chk("m.sat.error_count", 64'(error_count_s), 64'((m_errs > 3) ? 3 : m_errs));
`ifdef COUNT_CHECKER_STICKY_EN
    chk("m.err_sticky", 64'(err_sticky), 64'(m_sticky));
    chk("m.sat.err_sticky", 64'(err_sticky_s), 64'(m_sticky));
`endif
  end

  task automatic smp(input logic en, input logic [31:0] v);
    check_en = en;
    count_in = v;
    @(posedge clock);
    #1;
  endtask

  int sat_exp[5] = '{1, 2, 3, 3, 3};

  initial begin
    reset = 1'b0; check_en = 1'b0; count_in = '0; err_clear = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset.locked", 64'(locked), 64'd0);
    chk("reset.error", 64'(error), 64'd0);
    chk("reset.error_count", 64'(error_count), 64'd0);
    chk("reset.expected", 64'(expected), 64'd0);
    reset = 1'b1;

    // Clean lock
    for (int i = 0; i < 4; i++) smp(1, 32'(i));
    chk("lock.early", 64'(locked), 64'd0);
    smp(1, 4);
    chk("lock.rise", 64'(locked), 64'd1);
    chk("lock.no_error", 64'(error_count), 64'd0);

    // Discontinuity
    smp(1, 5); smp(1, 6); smp(1, 10);
    chk("disc.error", 64'(error), 64'd1);
    chk("disc.count", 64'(error_count), 64'd1);
    chk("disc.unlock", 64'(locked), 64'd0);
    chk("disc.expected", 64'(expected), 64'd11);
`ifdef COUNT_CHECKER_STICKY_EN
    chk("disc.sticky", 64'(err_sticky), 64'd1);
`endif
    smp(1, 11);
    chk("disc.pulse_end", 64'(error), 64'd0);
    smp(1, 12); smp(1, 13);
    chk("disc.still_sync", 64'(locked), 64'd0);
    smp(1, 14);
    chk("disc.relock", 64'(locked), 64'd1);

    // Wrap-around
    smp(0, 0);
    smp(1, 32'hFFFF_FFFD); smp(1, 32'hFFFF_FFFE); smp(1, 32'hFFFF_FFFF); smp(1, 0);
    chk("wrap.early", 64'(locked), 64'd0);
    smp(1, 1);
    chk("wrap.locked", 64'(locked), 64'd1);
    smp(1, 2);
    chk("wrap.no_error", 64'(error_count), 64'd1);

    // Enable drop holds count and expected
    smp(0, 32'd555);
    chk("drop.locked", 64'(locked), 64'd0);
    chk("drop.count", 64'(error_count), 64'd1);
    chk("drop.expected", 64'(expected), 64'd3);
    for (int i = 100; i < 105; i++) smp(1, 32'(i));
    chk("drop.relock", 64'(locked), 64'd1);
    chk("drop.relock_count", 64'(error_count), 64'd1);

    // Asynchronous reset mid-LOCKED
    #2 reset = 1'b0;
    #1;
    chk("areset.locked", 64'(locked), 64'd0);
    chk("areset.error_count", 64'(error_count), 64'd0);
    chk("areset.expected", 64'(expected), 64'd0);
    @(posedge clock);
    #1 reset = 1'b1;

    // Saturation on the ERR_W=2 instance
    for (int i = 0; i < 5; i++) smp(1, 32'(i));
    for (int k = 1; k <= 5; k++) begin
      smp(1, 32'(1000 * k));
      chk("sat.pulse", 64'(error_s), 64'd1);
      chk("sat.count", 64'(error_count_s), 64'(sat_exp[k-1]));
      for (int j = 1; j <= 4; j++) smp(1, 32'(1000 * k + j));
    end
    chk("sat.wide_count", 64'(error_count), 64'd5);

`ifdef COUNT_CHECKER_STICKY_EN
    smp(1, 5005);
    chk("sticky.persist", 64'(err_sticky), 64'd1);
    err_clear = 1'b1;
    smp(1, 5006);
    err_clear = 1'b0;
    chk("sticky.cleared", 64'(err_sticky), 64'd0);
    err_clear = 1'b1;
    smp(1, 9000);
    err_clear = 1'b0;
    chk("sticky.set_wins", 64'(err_sticky), 64'd1);
`endif

    smp(0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
